keypad_scanner: RTL and testbench

KEYPAD_SCANNER -- requirements
Module: keypad_scanner

---
 rtl/keypad_scanner.sv | 193 +++++++++++++++++++
 tb/tb_keypad_scanner.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column drive, row synchronizer, press/release debounce.
// Optional auto-repeat while a key is held is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scanner #(
    parameter int SCAN_DIV        = 4800,
    parameter int DEBOUNCE_CYCLES = 960000,
    parameter int REPEAT_CYCLES   = 24000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row_keys,
    output logic [3:0] col_keys,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int DEB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {SCAN = 2'd0, DEBOUNCE = 2'd1, HOLD = 2'd2, RELEASE = 2'd3} state_t;

    state_t           state_q, state_d;
    logic [3:0]       row_meta_q, row_sync_q;
    logic [DIV_W-1:0] div_q, div_d;
    logic [DEB_W-1:0] deb_q, deb_d;
    logic [3:0]       col_q, col_d;
    logic [3:0]       row_lat_q, row_lat_d;
    logic [3:0]       key_code_q, key_code_d;
    logic             key_valid_q, key_valid_d;
    logic             key_held_q, key_held_d;
    logic             lat_row_low_s;

`ifdef KEYPAD_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_CYCLES + 1);
    localparam logic [REP_W-1:0] REP_LAST = REP_W'(REPEAT_CYCLES - 1);
    logic [REP_W-1:0] rep_q, rep_d;
`endif

    function automatic logic is_onehot(input logic [3:0] v);
        is_onehot = (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
    endfunction

    function automatic logic [1:0] onehot_idx(input logic [3:0] v);
        case (v)
            4'b0001: onehot_idx = 2'd0;
            4'b0010: onehot_idx = 2'd1;
            4'b0100: onehot_idx = 2'd2;
            4'b1000: onehot_idx = 2'd3;
            default: onehot_idx = 2'd0;
        endcase
    endfunction

    function automatic logic [3:0] key_map(input logic [3:0] row, input logic [3:0] col);
        case ({onehot_idx(row), onehot_idx(col)})
            4'h0: key_map = 4'h1;  4'h1: key_map = 4'h2;  4'h2: key_map = 4'h3;  4'h3: key_map = 4'hA;
            4'h4: key_map = 4'h4;  4'h5: key_map = 4'h5;  4'h6: key_map = 4'h6;  4'h7: key_map = 4'hB;
            4'h8: key_map = 4'h7;  4'h9: key_map = 4'h8;  4'hA: key_map = 4'h9;  4'hB: key_map = 4'hC;
            4'hC: key_map = 4'hE;  4'hD: key_map = 4'h0;  4'hE: key_map = 4'hF;  4'hF: key_map = 4'hD;
            default: key_map = 4'h0;
        endcase
    endfunction

    assign lat_row_low_s = ((row_sync_q & row_lat_q) == 4'd0);

    // Next-state and datapath for the scan/debounce/hold/release sequence.
    always_comb begin
        state_d     = state_q;
        div_d       = div_q;
        deb_d       = deb_q;
        col_d       = col_q;
        row_lat_d   = row_lat_q;
        key_code_d  = key_code_q;
        key_valid_d = 1'b0;
`ifdef KEYPAD_REPEAT_EN
        rep_d       = rep_q;
`endif
        case (state_q)
            SCAN: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (is_onehot(row_sync_q)) begin
                        row_lat_d = row_sync_q;
                        deb_d     = '0;
                        state_d   = DEBOUNCE;
                    end else begin
                        col_d = {col_q[2:0], col_q[3]};
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            DEBOUNCE: begin
                if (row_sync_q == row_lat_q) begin
                    if (deb_q == DEB_LAST) begin
                        state_d     = HOLD;
                        key_code_d  = key_map(row_lat_q, col_q);
                        key_valid_d = 1'b1;
                        deb_d       = '0;
`ifdef KEYPAD_REPEAT_EN
                        rep_d       = '0;
`endif
                    end else begin
                        deb_d = deb_q + DEB_W'(1);
                    end
                end else begin
                    // Bounce: abandon the candidate and move on to the next column.
                    state_d = SCAN;
                    col_d   = {col_q[2:0], col_q[3]};
                    div_d   = '0;
                end
            end
            HOLD: begin
                if (lat_row_low_s) begin
                    deb_d   = '0;
                    state_d = RELEASE;
                end else begin
`ifdef KEYPAD_REPEAT_EN
                    if (rep_q == REP_LAST) begin
                        rep_d       = '0;
                        key_valid_d = 1'b1;
                    end else begin
                        rep_d = rep_q + REP_W'(1);
                    end
`else
                    state_d = HOLD;
`endif
                end
            end
            RELEASE: begin
                if (lat_row_low_s) begin
                    if (deb_q == DEB_LAST) begin
                        state_d = SCAN;
                        col_d   = {col_q[2:0], col_q[3]};
                        div_d   = '0;
                        deb_d   = '0;
                    end else begin
                        deb_d = deb_q + DEB_W'(1);
                    end
                end else begin
                    state_d = HOLD;
`ifdef KEYPAD_REPEAT_EN
                    rep_d   = '0;
`endif
                end
            end
            default: begin
                state_d = SCAN;
            end
        endcase
        key_held_d = (state_d == HOLD) || (state_d == RELEASE);
    end

    // State, synchronizer and registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= SCAN;
            row_meta_q  <= 4'd0;
            row_sync_q  <= 4'd0;
            div_q       <= '0;
            deb_q       <= '0;
            col_q       <= 4'b0001;
            row_lat_q   <= 4'd0;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            row_meta_q  <= row_keys;
            row_sync_q  <= row_meta_q;
            div_q       <= div_d;
            deb_q       <= deb_d;
            col_q       <= col_d;
            row_lat_q   <= row_lat_d;
            key_code_q  <= key_code_d;
            key_valid_q <= key_valid_d;
            key_held_q  <= key_held_d;
`ifdef KEYPAD_REPEAT_EN
            rep_q       <= rep_d;
`endif
        end
    end

    assign col_keys  = col_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a simple keypad model (row follows the driven column).
module tb_keypad_scanner;

    logic       clk;
    logic       reset;
    logic [3:0] row_keys;
    logic [3:0] col_keys;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;

    logic [3:0] press_row;
    logic [3:0] press_col;

    int checks;
    int errors;
    int cyc;
    int valid_cnt;
    int vt [0:63];

    keypad_scanner #(
        .SCAN_DIV       (4),
        .DEBOUNCE_CYCLES(16),
        .REPEAT_CYCLES  (32)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .row_keys (row_keys),
        .col_keys (col_keys),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    assign row_keys = ((col_keys & press_col) != 4'd0) ? press_row : 4'd0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (key_valid === 1'b1) begin
            if (valid_cnt < 64) vt[valid_cnt] <= cyc;
            valid_cnt <= valid_cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_col(input logic [3:0] c, input string tag);
        int n;
        n = 0;
        while (col_keys !== c && n < 64) begin
            step(1);
            n++;
        end
        check(tag, {28'd0, col_keys}, {28'd0, c});
    endtask

    task automatic press_and_check(input logic [3:0] r, input logic [3:0] c, input logic [3:0] code, input string tag);
        int base;
        base = valid_cnt;
        press_row = r;
        press_col = c;
        step(40);
        check({tag, "_code"}, {28'd0, key_code}, {28'd0, code});
        check({tag, "_held"}, {31'd0, key_held}, 32'd1);
        check({tag, "_pulses"}, valid_cnt - base, 32'd1);
        press_row = 4'd0;
        step(25);
        check({tag, "_released"}, {31'd0, key_held}, 32'd0);
    endtask

    initial begin
        int base;
        checks    = 0;
        errors    = 0;
        cyc       = 0;
        valid_cnt = 0;
        press_row = 4'd0;
        press_col = 4'd0;
        reset     = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_col", {28'd0, col_keys}, 32'h1);
        check("rst_code", {28'd0, key_code}, 32'h0);
        check("rst_valid", {31'd0, key_valid}, 32'h0);
        check("rst_held", {31'd0, key_held}, 32'h0);
        reset = 1'b1;

        // Idle scan: column index advances every SCAN_DIV edges.
        for (int n = 1; n <= 64; n++) begin
            logic [3:0] exp_col;
            @(posedge clk);
            #1;
            exp_col = 4'b0001 << ((n / 4) % 4);
            check("idle_col", {28'd0, col_keys}, {28'd0, exp_col});
        end
        check("idle_no_valid", valid_cnt, 32'd0);

        // Key 8 (row 2, column 1), then release glitch and full release.
        press_row = 4'b0100;
        press_col = 4'b0010;
        step(40);
        check("k8_pulses", valid_cnt, 32'd1);
        check("k8_code", {28'd0, key_code}, 32'h8);
        check("k8_held", {31'd0, key_held}, 32'd1);
        check("k8_frozen", {28'd0, col_keys}, 32'h2);
        press_row = 4'd0;
        step(5);
        check("glitch_held_low", {31'd0, key_held}, 32'd1);
        press_row = 4'b0100;
        step(10);
        check("glitch_held_back", {31'd0, key_held}, 32'd1);
        check("glitch_no_strobe", valid_cnt, 32'd1);
        press_row = 4'd0;
        step(25);
        check("k8_released", {31'd0, key_held}, 32'd0);
        check("k8_code_kept", {28'd0, key_code}, 32'h8);

        // Bounce on column 3: candidate dropped, scanning resumes at column 0.
        press_col = 4'b1000;
        for (int b = 0; b < 3; b++) begin
            wait_col(4'b0100, "bounce_wait0100");
            wait_col(4'b1000, "bounce_wait1000");
            press_row = 4'b0001;
            step(6);
            press_row = 4'd0;
            step(3);
            check("bounce_resume", {28'd0, col_keys}, 32'h1);
            check("bounce_not_held", {31'd0, key_held}, 32'd0);
        end
        check("bounce_no_strobe", valid_cnt, 32'd1);

        // Two rows at once on every column: ignored, scanning keeps moving.
        press_row = 4'b0011;
        press_col = 4'b1111;
        step(20);
        check("two_rows_held", {31'd0, key_held}, 32'd0);
        check("two_rows_no_strobe", valid_cnt, 32'd1);
        wait_col(4'b1000, "two_rows_scanning");
        press_row = 4'd0;
        press_col = 4'd0;

        // Key map corners.
        press_and_check(4'b0001, 4'b0001, 4'h1, "map_1");
        press_and_check(4'b1000, 4'b0001, 4'hE, "map_E");
        press_and_check(4'b1000, 4'b1000, 4'hD, "map_D");
        press_and_check(4'b0001, 4'b1000, 4'hA, "map_A");
        press_and_check(4'b0100, 4'b0100, 4'h9, "map_9");

        // Reset in the middle of debouncing key 4.
        base = valid_cnt;
        press_col = 4'b0001;
        wait_col(4'b1000, "rstdeb_wait1000");
        wait_col(4'b0001, "rstdeb_wait0001");
        press_row = 4'b0010;
        step(8);
        reset = 1'b0;
        #2;
        check("rstdeb_col", {28'd0, col_keys}, 32'h1);
        check("rstdeb_code", {28'd0, key_code}, 32'h0);
        check("rstdeb_valid", {31'd0, key_valid}, 32'h0);
        check("rstdeb_held", {31'd0, key_held}, 32'h0);
        press_row = 4'd0;
        @(negedge clk);
        reset = 1'b1;
        step(30);
        check("rstdeb_no_strobe", valid_cnt - base, 32'd0);
        check("rstdeb_code_after", {28'd0, key_code}, 32'h0);

        // Key 5 held long: single pulse, or repeats every 32 cycles when enabled.
        base = valid_cnt;
        press_row = 4'b0010;
        press_col = 4'b0010;
        step(110);
        press_row = 4'd0;
        step(25);
        check("k5_code", {28'd0, key_code}, 32'h5);
`ifdef KEYPAD_REPEAT_EN
        check("k5_pulses", valid_cnt - base, 32'd3);
        check("k5_rep1", vt[base + 1] - vt[base], 32'd32);
        check("k5_rep2", vt[base + 2] - vt[base + 1], 32'd32);
`else
        check("k5_pulses", valid_cnt - base, 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
